// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores through the memory controller,
// combinational pass-through for every other op.
module mem_stage #(
    parameter int OP_W   = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic [4:0]        in_w_addr,
    input  logic              in_w_req,
    input  logic [31:0]       in_w_data,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [OP_W-1:0]   in_aluop,
    input  logic              stall_in,
    input  logic              mc_ack,
    input  logic [7:0]        mc_rdata,
    output logic              mc_req,
    output logic              mc_we,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_wdata,
    output logic [4:0]        wb_w_addr,
    output logic              wb_w_req,
    output logic [31:0]       wb_w_data,
    output logic              stall_req
);

    localparam logic [OP_W-1:0] EX_LB  = OP_W'(8'h10);
    localparam logic [OP_W-1:0] EX_LH  = OP_W'(8'h11);
    localparam logic [OP_W-1:0] EX_LW  = OP_W'(8'h12);
    localparam logic [OP_W-1:0] EX_LBU = OP_W'(8'h13);
    localparam logic [OP_W-1:0] EX_LHU = OP_W'(8'h14);
    localparam logic [OP_W-1:0] EX_SB  = OP_W'(8'h18);
    localparam logic [OP_W-1:0] EX_SH  = OP_W'(8'h19);
    localparam logic [OP_W-1:0] EX_SW  = OP_W'(8'h1A);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [23:0] byte_buf;
    logic [31:0] result;
    logic        is_load, is_store, is_mem, sext;
    logic [1:0]  last_idx;
    logic        req_raw, stall_raw;
    logic [31:0] load_val;
    logic [31:0] wdata_shift;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        last_idx = 2'd0;
        case (in_aluop)
            EX_LB:   begin is_load = 1'b1;  sext = 1'b1; last_idx = 2'd0; end
            EX_LH:   begin is_load = 1'b1;  sext = 1'b1; last_idx = 2'd1; end
            EX_LW:   begin is_load = 1'b1;               last_idx = 2'd3; end
            EX_LBU:  begin is_load = 1'b1;               last_idx = 2'd0; end
            EX_LHU:  begin is_load = 1'b1;               last_idx = 2'd1; end
            EX_SB:   begin is_store = 1'b1;              last_idx = 2'd0; end
            EX_SH:   begin is_store = 1'b1;              last_idx = 2'd1; end
            EX_SW:   begin is_store = 1'b1;              last_idx = 2'd3; end
            default: ;
        endcase
        is_mem = is_load | is_store;
    end

    always_comb begin
        state_nxt = state;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    req_raw   = 1'b1;
                    stall_raw = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                req_raw   = 1'b1;
                stall_raw = 1'b1;
                if (mc_ack && idx == last_idx) state_nxt = DONE;
            end
            DONE: begin
                if (!stall_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The final byte bypasses byte_buf and is folded straight into result.
    always_comb begin
        load_val = 32'd0;
        case (last_idx)
            2'd0:    load_val = {{24{sext & mc_rdata[7]}}, mc_rdata};
            2'd1:    load_val = {{16{sext & mc_rdata[7]}}, mc_rdata, byte_buf[7:0]};
            default: load_val = {mc_rdata, byte_buf};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            byte_buf <= 24'd0;
            result   <= 32'd0;
        end else if (rdy) begin
            state <= state_nxt;
            if (state == BUSY && mc_ack) begin
                if (idx == last_idx) begin
                    idx <= 2'd0;
                    if (is_load) result <= load_val;
                end else begin
                    idx <= idx + 2'd1;
                    if (is_load) begin
                        case (idx)
                            2'd0:    byte_buf[7:0]   <= mc_rdata;
                            2'd1:    byte_buf[15:8]  <= mc_rdata;
                            default: byte_buf[23:16] <= mc_rdata;
                        endcase
                    end
                end
            end
        end
    end

    assign wdata_shift = in_w_data >> {idx, 3'b000};

    // Outputs are forced quiet while reset is asserted, even mid-access.
    always_comb begin
        mc_req    = rst_n & req_raw;
        stall_req = rst_n & stall_raw;
        mc_we     = mc_req & is_store;
        mc_addr   = mc_req ? in_mem_addr + ADDR_W'(idx) : '0;
        mc_wdata  = mc_we ? wdata_shift[7:0] : 8'd0;
    end

    always_comb begin
        wb_w_addr = 5'd0;
        wb_w_req  = 1'b0;
        wb_w_data = 32'd0;
        if (rst_n) begin
            if (is_store) begin
                wb_w_addr = in_w_addr;
            end else if (is_load) begin
                wb_w_addr = in_w_addr;
                wb_w_req  = in_w_req;
                wb_w_data = (state == DONE) ? result : 32'd0;
            end else begin
                wb_w_addr = in_w_addr;
                wb_w_req  = in_w_req;
                wb_w_data = in_w_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage; a byte-array memory model
// stands in for the controller and supplies expected load/store values.
module tb_mem_stage;

    localparam logic [7:0] EX_LB  = 8'h10;
    localparam logic [7:0] EX_LH  = 8'h11;
    localparam logic [7:0] EX_LW  = 8'h12;
    localparam logic [7:0] EX_LBU = 8'h13;
    localparam logic [7:0] EX_LHU = 8'h14;
    localparam logic [7:0] EX_SB  = 8'h18;
    localparam logic [7:0] EX_SH  = 8'h19;
    localparam logic [7:0] EX_SW  = 8'h1A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic [4:0]  in_w_addr = '0;
    logic        in_w_req = 1'b0;
    logic [31:0] in_w_data = '0;
    logic [31:0] in_mem_addr = '0;
    logic [7:0]  in_aluop = '0;
    logic        stall_in = 1'b0;
    logic        mc_ack = 1'b0;
    logic [7:0]  mc_rdata = '0;
    logic        mc_req, mc_we, wb_w_req, stall_req;
    logic [31:0] mc_addr, wb_w_data;
    logic [7:0]  mc_wdata;
    logic [4:0]  wb_w_addr;

    logic [7:0] mem [logic [31:0]];
    int checks = 0;
    int failures = 0;

    mem_stage #(.OP_W(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .in_w_addr(in_w_addr), .in_w_req(in_w_req), .in_w_data(in_w_data),
        .in_mem_addr(in_mem_addr), .in_aluop(in_aluop), .stall_in(stall_in),
        .mc_ack(mc_ack), .mc_rdata(mc_rdata),
        .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .wb_w_addr(wb_w_addr), .wb_w_req(wb_w_req), .wb_w_data(wb_w_data),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int numBytes(input logic [7:0] op);
        if (op == EX_LB || op == EX_LBU || op == EX_SB) return 1;
        if (op == EX_LH || op == EX_LHU || op == EX_SH) return 2;
        return 4;
    endfunction

    function automatic bit isLoad(input logic [7:0] op);
        return op == EX_LB || op == EX_LH || op == EX_LW || op == EX_LBU || op == EX_LHU;
    endfunction

    function automatic bit isStore(input logic [7:0] op);
        return op == EX_SB || op == EX_SH || op == EX_SW;
    endfunction

    // Little-endian value of the bytes in memory, then extended per op.
    function automatic logic [31:0] expectLoad(input logic [7:0] op, input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < numBytes(op); i++) v = v + (32'(mem[addr + 32'(i)]) << (8 * i));
        if (op == EX_LB) v = {{24{v[7]}}, v[7:0]};
        if (op == EX_LH) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] waddr, input logic wreq);
        in_aluop    = op;
        in_mem_addr = addr;
        in_w_data   = wdata;
        in_w_addr   = waddr;
        in_w_req    = wreq;
    endtask

    task automatic checkBusy(input logic [7:0] op, input logic [31:0] addr, input int i,
                             input logic [31:0] wdata, input logic wreq);
        logic [31:0] sh;
        sh = wdata >> (8 * i);
        checkOutput("busy_req", 32'(mc_req), 32'd1);
        checkOutput("busy_stall", 32'(stall_req), 32'd1);
        checkOutput("busy_addr", mc_addr, addr + 32'(i));
        checkOutput("busy_we", 32'(mc_we), 32'(isStore(op)));
        if (isStore(op)) checkOutput("busy_wdata", 32'(mc_wdata), 32'(sh[7:0]));
        checkOutput("busy_wbreq", 32'(wb_w_req), isStore(op) ? 32'd0 : 32'(wreq));
        checkOutput("busy_wbdata", wb_w_data, 32'd0);
    endtask

    // Called at a negedge with the stage in IDLE; returns at a negedge in IDLE.
    task automatic runMem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] waddr, input logic wreq, input bit rdyNoise, input int doneHold);
        logic [31:0] exp;
        logic [31:0] sh;
        applyStimulus(op, addr, wdata, waddr, wreq);
        #1;
        checkOutput("issue_req", 32'(mc_req), 32'd1);
        checkOutput("issue_stall", 32'(stall_req), 32'd1);
        checkOutput("issue_addr", mc_addr, addr);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < numBytes(op); i++) begin
            int gaps = $urandom_range(0, 2);
            logic [31:0] a = addr + 32'(i);
            for (int k = 0; k < gaps; k++) begin
                bit noise = rdyNoise && ($urandom_range(0, 1) == 1);
                rdy = !noise;
                mc_ack = noise;
                mc_rdata = 8'($urandom);
                #1 checkBusy(op, addr, i, wdata, wreq);
                @(posedge clk); @(negedge clk);
                rdy = 1'b1;
                mc_ack = 1'b0;
            end
            if (isLoad(op)) begin
                if (!mem.exists(a)) mem[a] = 8'($urandom);
                mc_rdata = mem[a];
            end else begin
                sh = wdata >> (8 * i);
                mem[a] = sh[7:0];
                mc_rdata = 8'($urandom);
            end
            mc_ack = 1'b1;
            #1 checkBusy(op, addr, i, wdata, wreq);
            @(posedge clk); @(negedge clk);
            mc_ack = 1'b0;
        end
        exp = isLoad(op) ? expectLoad(op, addr) : 32'd0;
        #1;
        checkOutput("done_req", 32'(mc_req), 32'd0);
        checkOutput("done_stall", 32'(stall_req), 32'd0);
        checkOutput("done_data", wb_w_data, exp);
        checkOutput("done_wbreq", 32'(wb_w_req), isLoad(op) ? 32'(wreq) : 32'd0);
        checkOutput("done_wbaddr", 32'(wb_w_addr), 32'(waddr));
        if (doneHold > 0) begin
            stall_in = 1'b1;
            for (int k = 0; k < doneHold; k++) begin
                mc_ack = 1'b1;
                @(posedge clk); @(negedge clk);
                #1;
                checkOutput("hold_req", 32'(mc_req), 32'd0);
                checkOutput("hold_stall", 32'(stall_req), 32'd0);
                checkOutput("hold_data", wb_w_data, exp);
            end
            mc_ack = 1'b0;
            stall_in = 1'b0;
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic runAlu(input logic [7:0] op, input logic [4:0] waddr, input logic wreq, input logic [31:0] wdata);
        applyStimulus(op, 32'($urandom), wdata, waddr, wreq);
        #1;
        checkOutput("alu_data", wb_w_data, wdata);
        checkOutput("alu_wbreq", 32'(wb_w_req), 32'(wreq));
        checkOutput("alu_wbaddr", 32'(wb_w_addr), 32'(waddr));
        checkOutput("alu_stall", 32'(stall_req), 32'd0);
        checkOutput("alu_req", 32'(mc_req), 32'd0);
        @(posedge clk); @(negedge clk);
        #1 checkOutput("alu_req_next", 32'(mc_req), 32'd0);
    endtask

    function automatic logic [7:0] randAluOp();
        logic [7:0] op;
        do op = 8'($urandom); while (isLoad(op) || isStore(op));
        return op;
    endfunction

    function automatic logic [7:0] randMemOp();
        logic [7:0] ops [8] = '{EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU, EX_SB, EX_SH, EX_SW};
        return ops[$urandom_range(0, 7)];
    endfunction

    initial begin
        #1;
        checkOutput("rst_req", 32'(mc_req), 32'd0);
        checkOutput("rst_stall", 32'(stall_req), 32'd0);
        checkOutput("rst_wbdata", wb_w_data, 32'd0);
        checkOutput("rst_mcaddr", mc_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runAlu(8'h01, 5'd5, 1'b1, 32'h0000_1234);

        mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56;
        mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
        runMem(EX_LW, 32'h1000, 32'h0, 5'd3, 1'b1, 1'b0, 0);
        checkOutput("lw_model", expectLoad(EX_LW, 32'h1000), 32'h1234_5678);

        mem[32'h2003] = 8'h80;
        runMem(EX_LB, 32'h2003, 32'h0, 5'd4, 1'b1, 1'b0, 0);
        runMem(EX_LBU, 32'h2003, 32'h0, 5'd4, 1'b1, 1'b0, 0);
        mem[32'h3000] = 8'h00; mem[32'h3001] = 8'h80;
        runMem(EX_LH, 32'h3000, 32'h0, 5'd6, 1'b1, 1'b0, 0);

        runMem(EX_SH, 32'h0FFF, 32'hAABB_CCDD, 5'd7, 1'b1, 1'b0, 0);
        checkOutput("sh_byte0", 32'(mem[32'h0FFF]), 32'h0000_00DD);
        checkOutput("sh_byte1", 32'(mem[32'h1000]), 32'h0000_00CC);

        runMem(EX_LW, 32'h1000, 32'h0, 5'd8, 1'b1, 1'b0, 3);
        runMem(EX_SW, 32'h4000, 32'hDEAD_BEEF, 5'd9, 1'b0, 1'b0, 0);

        // Reset in the middle of a word load, after two bytes have been acked.
        applyStimulus(EX_LW, 32'h5000, 32'h0, 5'd10, 1'b1);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            mc_ack = 1'b1;
            mc_rdata = 8'hEE;
            @(posedge clk); @(negedge clk);
            mc_ack = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(mc_req), 32'd0);
        checkOutput("midrst_stall", 32'(stall_req), 32'd0);
        checkOutput("midrst_wbaddr", 32'(wb_w_addr), 32'd0);
        checkOutput("midrst_mcaddr", mc_addr, 32'd0);
        applyStimulus(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runMem(EX_LW, 32'h6000, 32'h0, 5'd11, 1'b1, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                runAlu(randAluOp(), 5'($urandom), 1'($urandom), 32'($urandom));
            end else begin
                logic [31:0] addr;
                addr = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFE : 32'h7000 + 32'($urandom_range(0, 15));
                runMem(randMemOp(), addr, 32'($urandom), 5'($urandom), 1'($urandom),
                       1'b1, $urandom_range(0, 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
